vga_pattern_gen: RTL and testbench

- Parametrised VGA test-pattern generator.
- Contains its own horizontal/vertical timing counters and four selectable pattern modes, including an animated bouncing box.
- Drives the board VGA connector directly and serves as a bring-up and monitor-check source ahead of the scope display path.
- All outputs are registered and mutually aligned.

---
 rtl/vga_pkg.sv | 57 +++++
 rtl/vga_timing.sv | 57 +++++
 rtl/vga_pattern_gen.sv | 198 +++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, mode encodings and box motion helper
// for the VGA test-pattern generator.
package vga_pkg;

    localparam int DEF_COLOR_W  = 3;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_BOX_SIZE = 64;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_BOX   = 2'd3
    } mode_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       fwd;
    } axis_t;

    // One frame of bouncing motion along one axis; the sum is
    // kept at 11 bits so the far edge cannot wrap.
    function automatic axis_t axis_step(
        input logic [9:0] pos,
        input logic       fwd,
        input logic [3:0] step,
        input logic [9:0] lim
    );
        axis_t      r;
        logic [10:0] sum;
        sum   = {1'b0, pos} + {7'd0, step};
        r.pos = pos;
        r.fwd = fwd;
        if (fwd) begin
            if (sum >= {1'b0, lim}) begin
                r.pos = lim;
                r.fwd = 1'b0;
            end else begin
                r.pos = sum[9:0];
            end
        end else if (pos < {6'd0, step}) begin
            r.pos = '0;
            r.fwd = 1'b1;
        end else begin
            r.pos = pos - {6'd0, step};
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus unregistered sync and active-area decode.
// Outputs describe the current counter position.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       active,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int H_SE    = H_SS + H_SYNC;
    localparam int V_SS    = V_ACTIVE + V_FP;
    localparam int V_SE    = V_SS + V_SYNC;

    // Advance one pixel per clock, one line per horizontal wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == 10'(H_TOTAL - 1)) begin
            hc <= '0;
            vc <= (vc == 10'(V_TOTAL - 1)) ? '0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    // Decode sync windows and visible area from the position
    always_comb begin
        hsync  = ~HSYNC_POL;
        vsync  = ~VSYNC_POL;
        if (hc >= 10'(H_SS) && hc < 10'(H_SE))
            hsync = HSYNC_POL;
        if (vc >= 10'(V_SS) && vc < 10'(V_SE))
            vsync = VSYNC_POL;
        active = (hc < 10'(H_ACTIVE)) && (vc < 10'(V_ACTIVE));
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: frame-latched mode, bouncing box
// state, colour mux and an aligned output register stage.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   COLOR_W   = DEF_COLOR_W,
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   BOX_SIZE  = DEF_BOX_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [3:0]         step,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               video_on,
    output logic               frame_start,
    output logic [9:0]         pixel_x,
    output logic [9:0]         pixel_y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam logic [9:0]  BX_MAX = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  BY_MAX = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
    localparam logic [COLOR_W-1:0] ONES = '1;

    logic [9:0]         hc;
    logic [9:0]         vc;
    logic               active;
    logic               hsync_d;
    logic               vsync_d;
    logic               frame0;
    mode_t              mode_q;
    mode_t              mode_e;
    logic [3:0]         step_q;
    logic [3:0]         step_e;
    logic [9:0]         bx;
    logic [9:0]         by;
    logic               bx_fwd;
    logic               by_fwd;
    axis_t              hx;
    axis_t              vy;
    logic [9:0]         bar_cnt;
    logic [2:0]         bar_idx;
    logic               in_box;
    logic               chk;
    logic [COLOR_W-1:0] r_d;
    logic [COLOR_W-1:0] g_d;
    logic [COLOR_W-1:0] b_d;

    vga_timing #(
        .H_ACTIVE  (H_ACTIVE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_ACTIVE  (V_ACTIVE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .HSYNC_POL (HSYNC_POL),
        .VSYNC_POL (VSYNC_POL)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .hc     (hc),
        .vc     (vc),
        .active (active),
        .hsync  (hsync_d),
        .vsync  (vsync_d)
    );

    // Frame-boundary view: new mode/step and box position apply
    // from the very first pixel of the frame
    always_comb begin
        frame0 = (hc == '0) && (vc == '0);
        mode_e = frame0 ? mode_t'(mode) : mode_q;
        step_e = frame0 ? step : step_q;
        hx     = '{pos: bx, fwd: bx_fwd};
        vy     = '{pos: by, fwd: by_fwd};
        if (frame0) begin
            hx = axis_step(bx, bx_fwd, step_e, BX_MAX);
            vy = axis_step(by, by_fwd, step_e, BY_MAX);
        end
    end

    // Latch mode/step and move the box once per frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_BARS;
            step_q <= '0;
            bx     <= '0;
            by     <= '0;
            bx_fwd <= 1'b1;
            by_fwd <= 1'b1;
        end else if (frame0) begin
            mode_q <= mode_e;
            step_q <= step_e;
            bx     <= hx.pos;
            by     <= vy.pos;
            bx_fwd <= hx.fwd;
            by_fwd <= vy.fwd;
        end
    end

    // Bar index tracks hc by counting bar widths along the line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (hc == 10'(H_TOTAL - 1)) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (hc < 10'(H_ACTIVE)) begin
            if (bar_cnt == 10'(BAR_W - 1)) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 10'd1;
            end
        end
    end

    // Colour for the current position; black outside active area
    always_comb begin
        in_box = ({1'b0, hc} >= {1'b0, hx.pos})
              && ({1'b0, hc} <  {1'b0, hx.pos} + BOX_W)
              && ({1'b0, vc} >= {1'b0, vy.pos})
              && ({1'b0, vc} <  {1'b0, vy.pos} + BOX_W);
        chk = hc[5] ^ vc[5];
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (active) begin
            unique case (mode_e)
                MODE_BARS: begin
                    r_d = {COLOR_W{bar_idx[2]}};
                    g_d = {COLOR_W{bar_idx[1]}};
                    b_d = {COLOR_W{bar_idx[0]}};
                end
                MODE_CHECK: begin
                    r_d = {COLOR_W{chk}};
                    g_d = {COLOR_W{chk}};
                    b_d = {COLOR_W{chk}};
                end
                MODE_GRAD: begin
                    r_d = hc[COLOR_W+5:6];
                    g_d = vc[COLOR_W+5:6];
                    b_d = ONES;
                end
                MODE_BOX: begin
                    r_d = {COLOR_W{in_box}};
                    g_d = {COLOR_W{in_box}};
                    b_d = ONES;
                end
            endcase
        end
    end

    // Register every output together so they stay aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            HSYNC       <= ~HSYNC_POL;
            VSYNC       <= ~VSYNC_POL;
            R           <= '0;
            G           <= '0;
            B           <= '0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
        end else begin
            HSYNC       <= hsync_d;
            VSYNC       <= vsync_d;
            R           <= r_d;
            G           <= g_d;
            B           <= b_d;
            video_on    <= active;
            frame_start <= frame0;
            pixel_x     <= hc;
            pixel_y     <= vc;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a shrunken raster: directed
// vectors plus a per-pixel behavioural reference model.
module tb_vga_pattern_gen;

    localparam int HA  = 96;
    localparam int HFP = 2;
    localparam int HS  = 4;
    localparam int HBP = 2;
    localparam int VA  = 34;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int BS  = 16;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
        logic       von;
        logic       fs;
        logic [9:0] px;
        logic [9:0] py;
    } obs_t;

    typedef struct {
        int         md;
        int         x;
        int         y;
        logic [9:0] rgbv;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] step = 4'd0;
    logic       hsync;
    logic       vsync;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    logic       video_on;
    logic       frame_start;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;

    obs_t act;
    obs_t exp_o;
    int   checks = 0;
    int   errors = 0;

    int   m_hc = 0;
    int   m_vc = 0;
    int   m_mode = 0;
    int   m_bx = 0;
    int   m_by = 0;
    bit   m_dxr = 1'b1;
    bit   m_dyd = 1'b1;

    vec_t tbl [13];

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .COLOR_W (3),
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0),
        .BOX_SIZE (BS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .step        (step),
        .HSYNC       (hsync),
        .VSYNC       (vsync),
        .R           (r),
        .G           (g),
        .B           (b),
        .video_on    (video_on),
        .frame_start (frame_start),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y)
    );

    assign act = {hsync, vsync, r, g, b, video_on, frame_start,
                  pixel_x, pixel_y};

    function automatic obs_t reset_obs();
        obs_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    function automatic logic [2:0] full(input bit on);
        return on ? 3'd7 : 3'd0;
    endfunction

    // What the monitor should see for raster position (x, y)
    function automatic obs_t ref_pixel(input int x, input int y,
                                       input int md, input int bx,
                                       input int by);
        obs_t o;
        int   i;
        bit   inb;
        o     = '0;
        o.px  = 10'(x);
        o.py  = 10'(y);
        o.hs  = !(x >= HA + HFP && x < HA + HFP + HS);
        o.vs  = !(y >= VA + VFP && y < VA + VFP + VS);
        o.von = (x < HA) && (y < VA);
        o.fs  = (x == 0) && (y == 0);
        if (o.von) begin
            case (md)
                0: begin
                    i   = x / (HA / 8);
                    o.r = full(i >= 4);
                    o.g = full((i % 4) >= 2);
                    o.b = full((i % 2) == 1);
                end
                1: begin
                    i   = (x / 32 + y / 32) % 2;
                    o.r = full(i == 1);
                    o.g = full(i == 1);
                    o.b = full(i == 1);
                end
                2: begin
                    o.r = 3'((x / 64) % 8);
                    o.g = 3'((y / 64) % 8);
                    o.b = 3'd7;
                end
                default: begin
                    inb = x >= bx && x < bx + BS && y >= by && y < by + BS;
                    o.r = full(inb);
                    o.g = full(inb);
                    o.b = 3'd7;
                end
            endcase
        end
        return o;
    endfunction

    function automatic void bounce(inout int p, inout bit fwd,
                                   input int s, input int lim);
        if (fwd) begin
            if (p + s >= lim) begin
                p   = lim;
                fwd = 1'b0;
            end else begin
                p = p + s;
            end
        end else if (p < s) begin
            p   = 0;
            fwd = 1'b1;
        end else begin
            p = p - s;
        end
    endfunction

    // Reference model: tracks raster position and box motion
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_hc   = 0;
            m_vc   = 0;
            m_mode = 0;
            m_bx   = 0;
            m_by   = 0;
            m_dxr  = 1'b1;
            m_dyd  = 1'b1;
            exp_o  = reset_obs();
        end else begin
            if (m_hc == 0 && m_vc == 0) begin
                m_mode = int'(mode);
                bounce(m_bx, m_dxr, int'(step), HA - BS);
                bounce(m_by, m_dyd, int'(step), VA - BS);
            end
            exp_o = ref_pixel(m_hc, m_vc, m_mode, m_bx, m_by);
            m_hc++;
            if (m_hc == HT) begin
                m_hc = 0;
                m_vc++;
                if (m_vc == VT)
                    m_vc = 0;
            end
        end
    end

    // Every settled cycle is compared against the model
    initial forever begin
        @(negedge clk);
        checks++;
        if (act !== exp_o) begin
            errors++;
            $display("FAIL model t=%0t got %h want %h", $time, act, exp_o);
        end
    end

    task automatic check(input string name, input logic [63:0] a,
                         input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, a, e);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_frame");
    endtask

    task automatic goto_px(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (pixel_x == 10'(x) && pixel_y == 10'(y)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("goto_px");
    endtask

    task automatic wait_fall(input bit vsel, output int n);
        logic prev;
        logic cur;
        n    = 0;
        prev = vsel ? vsync : hsync;
        while (n < 2 * FRAME) begin
            @(negedge clk);
            n++;
            cur = vsel ? vsync : hsync;
            if (prev && !cur) return;
            prev = cur;
        end
        timeout("sync_fall");
    endtask

    task automatic low_width(input bit vsel, output int n);
        n = 0;
        while (((vsel ? vsync : hsync) == 1'b0) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        bit ok;
        int n;
        int w;

        tbl[0]  = '{0,  0,  0, {3'd0, 3'd0, 3'd0, 1'b1}};
        tbl[1]  = '{0, 12,  0, {3'd0, 3'd0, 3'd7, 1'b1}};
        tbl[2]  = '{0, 40,  3, {3'd0, 3'd7, 3'd7, 1'b1}};
        tbl[3]  = '{0, 95, 20, {3'd7, 3'd7, 3'd7, 1'b1}};
        tbl[4]  = '{0, 100, 20, {3'd0, 3'd0, 3'd0, 1'b0}};
        tbl[5]  = '{1, 32,  0, {3'd7, 3'd7, 3'd7, 1'b1}};
        tbl[6]  = '{1, 10, 10, {3'd0, 3'd0, 3'd0, 1'b1}};
        tbl[7]  = '{1,  5, 33, {3'd7, 3'd7, 3'd7, 1'b1}};
        tbl[8]  = '{1, 40, 33, {3'd0, 3'd0, 3'd0, 1'b1}};
        tbl[9]  = '{2, 64,  0, {3'd1, 3'd0, 3'd7, 1'b1}};
        tbl[10] = '{2, 63,  5, {3'd0, 3'd0, 3'd7, 1'b1}};
        tbl[11] = '{2, 95, 33, {3'd1, 3'd0, 3'd7, 1'b1}};
        tbl[12] = '{2, 50, 36, {3'd0, 3'd0, 3'd0, 1'b0}};

        repeat (3) @(negedge clk);
        check("rst_outputs", act, reset_obs());
        rst = 1'b1;
        @(negedge clk);
        check("first_frame_start", {frame_start, video_on, pixel_x, pixel_y},
              {1'b1, 1'b1, 10'd0, 10'd0});

        for (int k = 0; k < 13; k++) begin
            if (k == 0 || tbl[k].md != tbl[k-1].md) begin
                mode = 2'(tbl[k].md);
                wait_frame(ok);
            end
            goto_px(tbl[k].x, tbl[k].y, ok);
            if (ok) check($sformatf("vec%0d", k), {r, g, b, video_on},
                          tbl[k].rgbv);
        end

        wait_fall(1'b0, n);
        check("hs_start_x", pixel_x, 10'(HA + HFP));
        low_width(1'b0, w);
        check("hs_width", w, HS);
        wait_fall(1'b0, n);
        check("hs_period", n + w, HT);
        wait_fall(1'b1, n);
        check("vs_start", {pixel_x, pixel_y}, {10'd0, 10'(VA + VFP)});
        low_width(1'b1, w);
        check("vs_width", w, VS * HT);
        wait_frame(ok);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 2 * FRAME);
        check("frame_period", n, FRAME);

        mode = 2'd1;
        wait_frame(ok);
        goto_px(0, 20, ok);
        mode = 2'd2;
        goto_px(32, 25, ok);
        if (ok) check("latch_hold", {r, g, b}, {3'd7, 3'd7, 3'd7});
        wait_frame(ok);
        check("latch_new0", {r, g, b}, {3'd0, 3'd0, 3'd7});
        goto_px(64, 0, ok);
        if (ok) check("latch_new64", {r, g, b}, {3'd1, 3'd0, 3'd7});

        mode = 2'd3;
        step = 4'd15;
        repeat (7) wait_frame(ok);
        goto_px(64, 3, ok);
        if (ok) check("box_left_bg", {r, g, b}, {3'd0, 3'd0, 3'd7});
        goto_px(65, 3, ok);
        if (ok) check("box_corner", {r, g, b}, {3'd7, 3'd7, 3'd7});
        goto_px(80, 18, ok);
        if (ok) check("box_far", {r, g, b}, {3'd7, 3'd7, 3'd7});
        goto_px(80, 19, ok);
        if (ok) check("box_below", {r, g, b}, {3'd0, 3'd0, 3'd7});

        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                mode = 2'($urandom_range(0, 3));
                step = 4'($urandom_range(0, 15));
            end
        end

        mode = 2'd3;
        step = 4'd0;
        goto_px(50, 20, ok);
        #2 rst = 1'b0;
        #1 check("async_rst", act, reset_obs());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_box_origin", {frame_start, r, g, b},
              {1'b1, 3'd7, 3'd7, 3'd7});
        goto_px(15, 15, ok);
        if (ok) check("rst_box_in", {r, g, b}, {3'd7, 3'd7, 3'd7});
        goto_px(16, 15, ok);
        if (ok) check("rst_box_out", {r, g, b}, {3'd0, 3'd0, 3'd7});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
